// File: rtl/acc_ser_if.sv
// Handshake bundle between the upstream serial multiplier, the accumulator
// and whatever consumes the finished sums.
interface acc_ser_if #(
  parameter int G = 2
);
  logic            start;
  logic [15:0]     p;
  logic            p_valid;
  logic [15+G:0]   y;
  logic            y_valid;
  logic            busy;

  // Driver side: requests sums and feeds products.
  modport master (
    output start, p, p_valid,
    input  y, y_valid, busy
  );

  // Accumulator side.
  modport slave (
    input  start, p, p_valid,
    output y, y_valid, busy
  );
endinterface

// File: rtl/acc_ser.sv
// acc_ser: sums L signed 16-bit products into a (16+G)-bit result.
// A sum is started from IDLE, products are taken whenever p_valid is high
// in ACC (gaps allowed), and the result is published for one DONE cycle.
module acc_ser #(
  parameter int L = 4,
  parameter int G = 2
) (
  input  logic      clk,
  input  logic      reset,
  acc_ser_if.slave  bus
);

  localparam int W  = 16 + G;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    acc_reg, acc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [W-1:0]    y_reg, y_next;
  logic [W-1:0]    p_ext;

  // Product sign-extended to accumulator width; sums wrap modulo 2^W.
  assign p_ext = {{G{bus.p[15]}}, bus.p};

  // State and datapath registers; reset abandons any partial sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      y_reg     <= y_next;
    end
  end

  // Next-state and datapath updates. y is loaded on the edge that enters
  // DONE with the final sum (equal to acc in DONE), so y changes in the
  // same cycle y_valid is high.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = ACC;
          acc_next   = '0;
          count_next = '0;
        end
      end
      ACC: begin
        if (bus.p_valid) begin
          acc_next   = acc_reg + p_ext;
          count_next = count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_next = DONE;
            y_next     = acc_reg + p_ext;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = (state_reg == DONE);
  assign bus.busy    = (state_reg == ACC) || (state_reg == DONE);

endmodule

// File: tb/tb_acc_ser.sv
// Directed bench for acc_ser (L=4, G=2) with hand-computed sums.
module tb_acc_ser;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  acc_ser_if #(.G(2)) bus ();

  acc_ser #(.L(4), .G(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulses      = 0;

  logic [15:0] prods [4];
  int          gaps  [4];
  int          restart_at;

  // Free-running cycle count and y_valid pulse counter.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.y_valid === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sum of prods[] with gaps[] idle cycles before each product.
  task automatic sum4(input string tag, input logic [17:0] exp);
    int p0;
    p0 = pulses;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " busy in ACC"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.p_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) tick();
      bus.p       = prods[i];
      bus.p_valid = 1'b1;
      if (i == restart_at) bus.start = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.p_valid = 1'b0;
      if (i < 3) check({tag, " no early y_valid"}, 32'(bus.y_valid), 32'd0);
    end
    check({tag, " y_valid"}, 32'(bus.y_valid), 32'd1);
    check({tag, " y"}, 32'(bus.y), 32'(exp));
    check({tag, " busy in DONE"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, " y_valid drops"}, 32'(bus.y_valid), 32'd0);
    check({tag, " busy drops"}, 32'(bus.busy), 32'd0);
    check({tag, " y holds"}, 32'(bus.y), 32'(exp));
    check({tag, " one pulse"}, 32'(pulses - p0), 32'd1);
  endtask

  task automatic set_prods(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    prods[0] = a; prods[1] = b; prods[2] = c; prods[3] = d;
    for (int i = 0; i < 4; i++) gaps[i] = 0;
    restart_at = -1;
  endtask

  initial begin
    int p_before;
    int last_cyc;
    last_cyc    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.p       = 16'h1234;
    bus.p_valid = 1'b1;
    #1;
    check("reset y", 32'(bus.y), 32'd0);
    check("reset y_valid", 32'(bus.y_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    tick();
    tick();
    check("reset held busy", 32'(bus.busy), 32'd0);
    bus.start   = 1'b0;
    bus.p_valid = 1'b0;
    reset       = 1'b0;
    tick();
    check("idle ignores p_valid", 32'(bus.busy), 32'd0);

    set_prods(16'd100, 16'd200, 16'd300, 16'd400);
    sum4("basic", 18'h003E8);

    set_prods(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    sum4("min x4", 18'h20000);
    set_prods(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    sum4("max x4", 18'h1FFFC);

    set_prods(16'd5, -16'sd3, 16'd7, -16'sd9);
    gaps[0] = 0; gaps[1] = 3; gaps[2] = 1; gaps[3] = 2;
    sum4("gaps", 18'h00000);

    set_prods(16'd10, 16'd20, 16'd30, 16'd40);
    restart_at = 2;
    sum4("restart ignored", 18'd100);

    // Abort a sum with reset after two products.
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.p_valid = 1'b1;
    bus.p       = 16'd11;
    tick();
    bus.p       = 16'd22;
    tick();
    bus.p_valid = 1'b0;
    p_before    = pulses;
    reset       = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort y", 32'(bus.y), 32'd0);
    check("abort y_valid", 32'(bus.y_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort no pulse", 32'(pulses - p_before), 32'd0);
    set_prods(16'd1, 16'd2, 16'd3, 16'd4);
    sum4("after abort", 18'd10);

    // start held high, p_valid held high: back-to-back sums every 6 cycles.
    bus.start   = 1'b1;
    bus.p_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.p = 16'h7FFF;
      tick();
      for (int i = 0; i < 4; i++) begin
        bus.p = 16'(100 * k + i);
        tick();
      end
      check($sformatf("stream %0d y_valid", k), 32'(bus.y_valid), 32'd1);
      check($sformatf("stream %0d y", k), 32'(bus.y), 32'(400 * k + 6));
      if (k > 1) check($sformatf("stream %0d period", k), 32'(cyc - last_cyc), 32'd6);
      last_cyc = cyc;
      bus.p = 16'h7FFF;
      tick();
      check($sformatf("stream %0d y_valid drops", k), 32'(bus.y_valid), 32'd0);
    end
    bus.start   = 1'b0;
    bus.p_valid = 1'b0;
    tick();
    check("stream end idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
